modcount_checker: RTL and testbench

MODCOUNT_CHECKER -- requirements
Module: modcount_checker

---
 rtl/modcount_pkg.sv | 14 +
 rtl/modcount_checker_if.sv | 29 ++
 rtl/modcount_next.sv | 26 ++
 rtl/modcount_checker.sv | 118 +++++++++++
 tb/tb_modcount_checker.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/modcount_pkg.sv
// Shared types and default sizing for the modulo-counter checker.
package modcount_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefMod   = 10;
    localparam int unsigned DefCntw  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StResync
    } state_e;

endpackage

// File: rtl/modcount_checker_if.sv
// Observed-counter signals in, checker status out; master drives the observed counter side.
interface modcount_checker_if
    import modcount_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNTW  = DefCntw
);

    logic             chk_en;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] ld;
    logic             lde;
    logic             err;
    logic             ld_err;
    logic [CNTW-1:0]  err_cnt;
    logic [CNTW-1:0]  wrap_cnt;
    logic             locked;

    modport master (
        output chk_en, q, ld, lde,
        input  err, ld_err, err_cnt, wrap_cnt, locked
    );

    modport slave (
        input  chk_en, q, ld, lde,
        output err, ld_err, err_cnt, wrap_cnt, locked
    );

endinterface

// File: rtl/modcount_next.sv
// Next value of a modulo-MOD counter with synchronous load.
module modcount_next
    import modcount_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned MOD   = DefMod
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] ld,
    input  logic             lde,
    output logic [WIDTH-1:0] next
);

    localparam logic [WIDTH-1:0] Top = WIDTH'(MOD - 1);

    always_comb begin
        if (lde) begin
            next = ld;
        end else if (v == Top) begin
            next = '0;
        end else begin
            next = v + WIDTH'(1);
        end
    end

endmodule

// File: rtl/modcount_checker.sv
// Shadows an external modulo counter, flags count mismatches and illegal loads,
// and keeps saturating error and wrapping rollover tallies.
module modcount_checker
    import modcount_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned MOD   = DefMod,
    parameter int unsigned CNTW  = DefCntw
) (
    input  logic                 clk,
    input  logic                 rst,
    modcount_checker_if.slave    bus
);

    localparam logic [WIDTH-1:0] Top    = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   ModW   = (WIDTH + 1)'(MOD);
    localparam logic [CNTW-1:0]  CntMax = '1;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_exp, w_exp_d;
    logic [WIDTH-1:0] w_next_exp, w_next_q;
    logic             r_err, w_err_d;
    logic             r_ld_err, w_ld_err_d;
    logic [CNTW-1:0]  r_err_cnt, w_err_cnt_d;
    logic [CNTW-1:0]  r_wrap_cnt, w_wrap_cnt_d;
    logic             r_locked, w_locked_d;

    logic w_checking, w_match, w_mis, w_bad_ld;

    modcount_next #(.WIDTH(WIDTH), .MOD(MOD)) u_next_exp (
        .v    (r_exp),
        .ld   (bus.ld),
        .lde  (bus.lde),
        .next (w_next_exp)
    );

    modcount_next #(.WIDTH(WIDTH), .MOD(MOD)) u_next_q (
        .v    (bus.q),
        .ld   (bus.ld),
        .lde  (bus.lde),
        .next (w_next_q)
    );

    assign w_checking = bus.chk_en && (r_state != StIdle);
    assign w_match    = (bus.q == r_exp);
    assign w_mis      = bus.chk_en && (r_state == StTrack) && !w_match;
    assign w_bad_ld   = w_checking && bus.lde && ({1'b0, bus.ld} >= ModW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StTrack;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (!bus.chk_en) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle:   w_state_d = StResync;
                StTrack:  w_state_d = (w_mis || w_bad_ld) ? StResync : StTrack;
                StResync: w_state_d = w_bad_ld ? StResync : StTrack;
                default:  w_state_d = StResync;
            endcase
        end
    end

    // Flags and tallies only move while checking; IDLE just follows q.
    always_comb begin
        w_exp_d      = w_next_q;
        w_err_d      = 1'b0;
        w_ld_err_d   = 1'b0;
        w_err_cnt_d  = r_err_cnt;
        w_wrap_cnt_d = r_wrap_cnt;
        w_locked_d   = (w_state_d == StTrack);
        if (w_checking) begin
            w_err_d    = w_mis;
            w_ld_err_d = w_bad_ld;
            if (r_state == StTrack && w_match) begin
                w_exp_d = w_next_exp;
                if (r_exp == Top && !bus.lde) begin
                    w_wrap_cnt_d = r_wrap_cnt + CNTW'(1);
                end
            end
            if ((w_mis || w_bad_ld) && r_err_cnt != CntMax) begin
                w_err_cnt_d = r_err_cnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp      <= '0;
            r_err      <= 1'b0;
            r_ld_err   <= 1'b0;
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
            r_locked   <= 1'b1;
        end else begin
            r_exp      <= w_exp_d;
            r_err      <= w_err_d;
            r_ld_err   <= w_ld_err_d;
            r_err_cnt  <= w_err_cnt_d;
            r_wrap_cnt <= w_wrap_cnt_d;
            r_locked   <= w_locked_d;
        end
    end

    assign bus.err      = r_err;
    assign bus.ld_err   = r_ld_err;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.wrap_cnt = r_wrap_cnt;
    assign bus.locked   = r_locked;

endmodule

// File: tb/tb_modcount_checker.sv
// Directed bench for modcount_checker (MOD=10) with a rule-level reference model.
module tb_modcount_checker;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int CNTW  = 8;

    localparam int MIdle   = 0;
    localparam int MTrack  = 1;
    localparam int MResync = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    modcount_checker_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    modcount_checker #(.WIDTH(WIDTH), .MOD(MOD), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode, m_exp, m_ec, m_wc;
    bit m_err, m_lerr;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nxt(input int v, input int l, input bit le);
        if (le) return l;
        if (v == MOD - 1) return 0;
        return (v + 1) % (1 << WIDTH);
    endfunction

    // Model: expected value is always the successor of what q showed.
    always @(posedge clk) begin
        int  qv, lv;
        bit  mis, bad;
        qv = int'(bus.q);
        lv = int'(bus.ld);
        if (rst) begin
            m_mode = MTrack; m_exp = 0; m_err = 0; m_lerr = 0; m_ec = 0; m_wc = 0;
            m_valid = 1'b1;
        end else if (!bus.chk_en) begin
            m_mode = MIdle; m_exp = nxt(qv, lv, bus.lde); m_err = 0; m_lerr = 0;
        end else if (m_mode == MIdle) begin
            m_mode = MResync; m_exp = nxt(qv, lv, bus.lde); m_err = 0; m_lerr = 0;
        end else begin
            mis = (m_mode == MTrack) && (qv != m_exp);
            bad = bus.lde && (lv >= MOD);
            if (m_mode == MTrack && !mis && qv == MOD - 1 && !bus.lde)
                m_wc = (m_wc + 1) % (1 << CNTW);
            if ((mis || bad) && m_ec < (1 << CNTW) - 1) m_ec = m_ec + 1;
            m_err  = mis;
            m_lerr = bad;
            m_exp  = nxt(qv, lv, bus.lde);
            m_mode = (mis || bad) ? MResync : MTrack;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("err", int'(bus.err), int'(m_err));
            chk("ld_err", int'(bus.ld_err), int'(m_lerr));
            chk("err_cnt", int'(bus.err_cnt), m_ec);
            chk("wrap_cnt", int'(bus.wrap_cnt), m_wc);
            chk("locked", int'(bus.locked), int'(m_mode == MTrack));
        end
    end

    // Apply one cycle of inputs and return after the following falling edge.
    task automatic cyc(input bit r, input bit c, input int qv, input int lv, input bit le);
        rst        = r;
        bus.chk_en = c;
        bus.q      = WIDTH'(qv);
        bus.ld     = WIDTH'(lv);
        bus.lde    = le;
        @(negedge clk);
    endtask

    initial begin
        bus.chk_en = 1'b1; bus.q = '0; bus.ld = '0; bus.lde = 1'b0;
        cyc(1, 1, 0, 0, 0);
        chk("rst_locked", int'(bus.locked), 1);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
        chk("rst_wrap_cnt", int'(bus.wrap_cnt), 0);

        for (int i = 0; i < 25; i++) cyc(0, 1, i % 10, 0, 0);
        chk("run_wrap", int'(bus.wrap_cnt), 2);
        chk("run_err_cnt", int'(bus.err_cnt), 0);
        chk("run_locked", int'(bus.locked), 1);

        for (int i = 5; i < 13; i++) cyc(0, 1, i % 10, 0, 0);
        cyc(0, 1, 3, 7, 1);
        cyc(0, 1, 7, 0, 0);
        cyc(0, 1, 8, 0, 0);
        chk("load_wrap", int'(bus.wrap_cnt), 3);
        chk("load_err_cnt", int'(bus.err_cnt), 0);

        cyc(0, 1, 9, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 0);
        cyc(0, 1, 5, 0, 0);
        chk("mis_err", int'(bus.err), 1);
        chk("mis_err_cnt", int'(bus.err_cnt), 1);
        chk("mis_locked", int'(bus.locked), 0);
        cyc(0, 1, 6, 0, 0);
        chk("mis_relock", int'(bus.locked), 1);
        cyc(0, 1, 7, 0, 0);
        chk("mis_accept", int'(bus.err), 0);

        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 12, 1);
        chk("bad_ld_err", int'(bus.ld_err), 1);
        chk("bad_ld_cnt", int'(bus.err_cnt), 1);
        chk("bad_locked", int'(bus.locked), 0);
        cyc(0, 1, 12, 0, 0);
        cyc(0, 1, 13, 0, 0);
        chk("bad_relock", int'(bus.locked), 1);
        chk("bad_no_err", int'(bus.err), 0);

        cyc(0, 1, 2, 15, 1);
        chk("both_err", int'(bus.err), 1);
        chk("both_ld_err", int'(bus.ld_err), 1);
        chk("both_cnt", int'(bus.err_cnt), 2);
        cyc(0, 1, 15, 0, 0);
        cyc(0, 1, 0, 0, 0);

        cyc(0, 0, 7, 0, 0);
        cyc(0, 0, 3, 0, 0);
        cyc(0, 0, 9, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("idle_locked", int'(bus.locked), 0);
        chk("idle_cnt", int'(bus.err_cnt), 2);
        cyc(0, 1, 5, 0, 0);
        cyc(0, 1, 6, 0, 0);
        cyc(0, 1, 7, 0, 0);
        chk("idle_relock", int'(bus.locked), 1);

        for (int i = 0; i < 620; i++) cyc(0, 1, 3, 0, 0);
        chk("sat_cnt", int'(bus.err_cnt), 255);

        cyc(1, 1, 6, 2, 1);
        chk("rst2_cnt", int'(bus.err_cnt), 0);
        chk("rst2_wrap", int'(bus.wrap_cnt), 0);
        chk("rst2_locked", int'(bus.locked), 1);
        cyc(0, 1, 0, 0, 0);
        chk("rst2_accept", int'(bus.err), 0);
        cyc(0, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
